cacheline_adaptor: RTL and testbench

Sits directly downstream of the L1 cache controller, between its 256-bit physical-memory port and the 64-bit burst DRAM model. Converts one cacheline read or write request into a 4-beat, 64-bit burst on the memory side. Returns a single-cycle completion response (resp_o) upstream, which the cache controller consumes as pmem_resp.

---
 rtl/cacheline_adaptor.sv | 133 +++++++++++++
 tb/tb_cacheline_adaptor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Bridges the L1 cache controller's 256-bit physical-memory port to a
//   64-bit burst DRAM model. One cacheline read or write becomes a
//   BURST_LEN-beat burst; completion is signalled upstream with a one-cycle
//   resp_o pulse.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   line_i / line_o      write-back line from cache / filled line to cache
//   address_i            line address from cache
//   read_i / write_i     level requests from cache, held until resp_o
//   resp_o               one-cycle completion pulse to cache
//   burst_i / burst_o    read beat from memory / write beat to memory
//   address_o            line-aligned burst address to memory
//   read_o / write_o     memory read / write request
//   resp_i               memory beat-valid / beat-accept strobe
module cacheline_adaptor #(
    parameter int BURST_W   = 64,
    parameter int BURST_LEN = 4,
    parameter int LINE_W    = 256,
    parameter int OFFSET_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   count;
    logic [LINE_W-1:0]  buffer;
    logic [31:0]        addr_q;

    // Offset bits never reach memory; the burst always starts on a line boundary.
    logic unused_offset_bits;
    assign unused_offset_bits = ^address_i[OFFSET_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            buffer <= '0;
            addr_q <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (read_i || write_i) begin
                        addr_q <= {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
                        count  <= '0;
                        // Read has priority, so line_i is captured only for a pure write.
                        if (!read_i) begin
                            buffer <= line_i;
                        end
                    end
                end
                READ: begin
                    if (resp_i) begin
                        buffer[BURST_W*count +: BURST_W] <= burst_i;
                        count <= count + 1'b1;
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (read_i) begin
                    next_state = READ;
                end else if (write_i) begin
                    next_state = WRITE;
                end
            end
            READ, WRITE: begin
                if (resp_i && (count == LAST_BEAT)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register, so they are glitch-free
    // and drop immediately on an asynchronous reset.
    always_comb begin
        read_o    = (state == READ);
        write_o   = (state == WRITE);
        resp_o    = (state == DONE);
        address_o = addr_q;
        line_o    = buffer;
        burst_o   = '0;
        if (state == WRITE) begin
            burst_o = buffer[BURST_W*count +: BURST_W];
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor
//   Directed self-checking bench for cacheline_adaptor. Inputs are driven and
//   outputs sampled on the falling clock edge, so values set at one falling
//   edge are sampled by the DUT at the following rising edge.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks;
    int passed;
    int fails;

    cacheline_adaptor #(
        .BURST_W  (64),
        .BURST_LEN(4),
        .LINE_W   (256),
        .OFFSET_W (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .line_i   (line_i),
        .line_o   (line_o),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .resp_o   (resp_o),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .resp_i   (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic rd, input logic wr, input logic rsp);
        check({tag, ".read_o"}, 256'(read_o), 256'(rd));
        check({tag, ".write_o"}, 256'(write_o), 256'(wr));
        check({tag, ".resp_o"}, 256'(resp_o), 256'(rsp));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Zero-wait read: caller is at the first READ cycle; returns in the DONE cycle.
    task automatic read_burst(input string tag, input logic [255:0] line);
        for (int i = 0; i < 4; i++) begin
            ctl({tag, ".beat"}, 1'b1, 1'b0, 1'b0);
            resp_i  = 1'b1;
            burst_i = line[64*i +: 64];
            step();
        end
        resp_i  = 1'b0;
        burst_i = '0;
    endtask

    // Zero-wait write: caller is at the first WRITE cycle; returns in the DONE cycle.
    task automatic write_burst(input string tag, input logic [255:0] line);
        for (int i = 0; i < 4; i++) begin
            ctl({tag, ".beat"}, 1'b0, 1'b1, 1'b0);
            check({tag, ".burst_o"}, 256'(burst_o), 256'(line[64*i +: 64]));
            resp_i = 1'b1;
            step();
        end
        resp_i = 1'b0;
    endtask

    logic [255:0] cnt_line;
    logic [63:0]  cnt_beat [4];
    logic [255:0] rd_line;
    logic [255:0] wr_line;
    int           stall_pat [7];
    int           stall_idx [7];

    initial begin
        checks    = 0;
        passed    = 0;
        fails     = 0;
        rst       = 1'b1;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;

        cnt_beat[0] = 64'h0706050403020100;
        cnt_beat[1] = 64'h0F0E0D0C0B0A0908;
        cnt_beat[2] = 64'h1716151413121110;
        cnt_beat[3] = 64'h1F1E1D1C1B1A1918;
        cnt_line    = {cnt_beat[3], cnt_beat[2], cnt_beat[1], cnt_beat[0]};
        stall_pat   = '{1, 0, 0, 1, 1, 0, 1};
        stall_idx   = '{0, 1, 1, 1, 2, 3, 3};

        // Reset state
        step();
        step();
        ctl("reset", 1'b0, 1'b0, 1'b0);
        check("reset.address_o", 256'(address_o), 256'h0);
        check("reset.line_o", line_o, 256'h0);
        check("reset.burst_o", 256'(burst_o), 256'h0);
        rst = 1'b0;

        // resp_i alone in IDLE does nothing
        resp_i = 1'b1;
        step();
        resp_i = 1'b0;
        step();
        ctl("idle_resp", 1'b0, 1'b0, 1'b0);

        // Zero-wait read
        address_i = 32'h0000_1234;
        read_i    = 1'b1;
        step();
        check("rd.address_o", 256'(address_o), 256'h0000_1220);
        rd_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        read_burst("rd", rd_line);
        ctl("rd.done", 1'b0, 1'b0, 1'b1);
        check("rd.line_o", line_o, rd_line);
        step();
        ctl("rd.idle", 1'b0, 1'b0, 1'b0);
        read_i = 1'b0;
        step();
        ctl("rd.after", 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-read after two beats
        address_i = 32'h0000_ABCD;
        read_i    = 1'b1;
        step();
        resp_i  = 1'b1;
        burst_i = 64'hAAAA_0000_0000_0000;
        step();
        burst_i = 64'hAAAA_1111_1111_1111;
        step();
        resp_i  = 1'b0;
        burst_i = '0;
        ctl("rst_mid.pre", 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        ctl("rst_mid", 1'b0, 1'b0, 1'b0);
        check("rst_mid.address_o", 256'(address_o), 256'h0);
        check("rst_mid.line_o", line_o, 256'h0);
        step();
        rst       = 1'b0;
        address_i = 32'h0000_5678;
        read_i    = 1'b1;
        step();
        check("rst_rd.address_o", 256'(address_o), 256'h0000_5660);
        rd_line = {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
                   64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001};
        read_burst("rst_rd", rd_line);
        ctl("rst_rd.done", 1'b0, 1'b0, 1'b1);
        check("rst_rd.line_o", line_o, rd_line);
        step();
        read_i = 1'b0;
        step();

        // Write with stalls: resp_i pattern 1,0,0,1,1,0,1
        address_i = 32'h0000_205F;
        line_i    = cnt_line;
        write_i   = 1'b1;
        step();
        check("wst.address_o", 256'(address_o), 256'h0000_2040);
        for (int c = 0; c < 7; c++) begin
            ctl("wst.cycle", 1'b0, 1'b1, 1'b0);
            check("wst.burst_o", 256'(burst_o), 256'(cnt_beat[stall_idx[c]]));
            resp_i = (stall_pat[c] != 0);
            step();
        end
        resp_i = 1'b0;
        ctl("wst.done", 1'b0, 1'b0, 1'b1);
        step();
        write_i = 1'b0;
        ctl("wst.idle", 1'b0, 1'b0, 1'b0);
        step();

        // Back-to-back write then read, each request held through resp_o
        wr_line   = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                     64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
        address_i = 32'h0000_0100;
        line_i    = wr_line;
        write_i   = 1'b1;
        step();
        check("b2b_wr.address_o", 256'(address_o), 256'h0000_0100);
        write_burst("b2b_wr", wr_line);
        ctl("b2b_wr.done", 1'b0, 1'b0, 1'b1);
        step();
        ctl("b2b.gap", 1'b0, 1'b0, 1'b0);
        write_i   = 1'b0;
        read_i    = 1'b1;
        address_i = 32'h0000_0210;
        step();
        check("b2b_rd.address_o", 256'(address_o), 256'h0000_0200);
        rd_line = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                   64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};
        read_burst("b2b_rd", rd_line);
        ctl("b2b_rd.done", 1'b0, 1'b0, 1'b1);
        check("b2b_rd.line_o", line_o, rd_line);
        step();
        read_i = 1'b0;
        ctl("b2b.idle", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            ctl("b2b.quiet", 1'b0, 1'b0, 1'b0);
        end

        // Simultaneous read and write: read wins
        read_i    = 1'b1;
        write_i   = 1'b1;
        line_i    = {4{64'h5555_5555_5555_5555}};
        address_i = 32'h0000_0300;
        step();
        rd_line = {64'h0123_4567_89AB_CDEF, 64'h1122_3344_5566_7788,
                   64'h99AA_BBCC_DDEE_FF00, 64'h0F1E_2D3C_4B5A_6978};
        read_burst("both", rd_line);
        ctl("both.done", 1'b0, 1'b0, 1'b1);
        check("both.line_o", line_o, rd_line);
        step();
        read_i  = 1'b0;
        write_i = 1'b0;
        step();
        ctl("both.idle", 1'b0, 1'b0, 1'b0);

        // Inputs change during write beat 1
        address_i = 32'h0000_0400;
        line_i    = cnt_line;
        write_i   = 1'b1;
        step();
        check("chg.beat0", 256'(burst_o), 256'(cnt_beat[0]));
        resp_i = 1'b1;
        step();
        address_i = 32'hFFFF_FFFF;
        line_i    = '1;
        #1;
        check("chg.beat1", 256'(burst_o), 256'(cnt_beat[1]));
        check("chg.addr1", 256'(address_o), 256'h0000_0400);
        step();
        check("chg.beat2", 256'(burst_o), 256'(cnt_beat[2]));
        check("chg.addr2", 256'(address_o), 256'h0000_0400);
        step();
        check("chg.beat3", 256'(burst_o), 256'(cnt_beat[3]));
        ctl("chg.beat3", 1'b0, 1'b1, 1'b0);
        step();
        resp_i = 1'b0;
        ctl("chg.done", 1'b0, 1'b0, 1'b1);
        check("chg.addr_done", 256'(address_o), 256'h0000_0400);
        step();
        write_i = 1'b0;
        step();
        ctl("chg.idle", 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
